// File: rtl/gray_seq_checker.sv
// Gray-count sequence checker: decodes the upstream Gray count, accepts single
// legal steps, counts wraps and latches a fault on any illegal transition.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no reference yet; the next valid sample is taken as-is
// S_TRACK | reference held in last_bin/last_ovf; each sample is checked
// S_FAULT | illegal transition seen; samples ignored until clr_err
module gray_seq_checker #(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [WIDTH-1:0]  gray,
  input  logic              overflow,
  input  logic              clr_err,
  output logic [WIDTH-1:0]  binary,
  output logic              step,
  output logic              resync,
  output logic [WRAP_W-1:0] wraps,
  output logic              error
);

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_FAULT} state_t;

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    last_bin, last_bin_nxt, nb, bin_inc;
  logic                last_ovf, last_ovf_nxt;
  logic                step_nxt, resync_nxt;
  logic [WRAP_W-1:0]   wraps_nxt;
  logic                is_max, ovf_same, hold, legal_inc, legal_wrap, upstream_rst;

  // Bit i of the binary value is the XOR of all Gray bits from i upward.
  always_comb begin
    nb = '0;
    for (int i = 0; i < WIDTH; i++) nb[i] = ^(gray >> i);
  end

  assign bin_inc      = last_bin + 1'b1;
  assign is_max       = &last_bin;
  assign ovf_same     = (overflow == last_ovf);
  assign hold         = (nb == last_bin) && ovf_same;
  assign legal_inc    = !is_max && (nb == bin_inc) && ovf_same;
  assign legal_wrap   = is_max && (nb == '0) && overflow;
  assign upstream_rst = (nb == '0) && !overflow && (!is_max || last_ovf);

  always_comb begin
    state_nxt    = state;
    last_bin_nxt = last_bin;
    last_ovf_nxt = last_ovf;
    step_nxt     = 1'b0;
    resync_nxt   = 1'b0;
    wraps_nxt    = wraps;
    case (state)
      S_IDLE: begin
        if (valid) begin
          last_bin_nxt = nb;
          last_ovf_nxt = overflow;
          state_nxt    = S_TRACK;
        end
      end
      S_TRACK: begin
        if (valid && !hold) begin
          if (legal_inc || legal_wrap || upstream_rst) begin
            last_bin_nxt = nb;
            last_ovf_nxt = overflow;
            step_nxt     = legal_inc || legal_wrap;
            resync_nxt   = !(legal_inc || legal_wrap);
            if (legal_wrap && !(&wraps)) wraps_nxt = wraps + 1'b1;
          end else begin
            state_nxt = S_FAULT;
          end
        end
      end
      S_FAULT: begin
        // clear takes priority over any sample arriving in the same cycle
        if (clr_err) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      last_bin <= '0;
      last_ovf <= 1'b0;
      step     <= 1'b0;
      resync   <= 1'b0;
      wraps    <= '0;
      error    <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_bin <= last_bin_nxt;
      last_ovf <= last_ovf_nxt;
      step     <= step_nxt;
      resync   <= resync_nxt;
      wraps    <= wraps_nxt;
      error    <= (state_nxt == S_FAULT);
    end
  end

  assign binary = last_bin;

endmodule

// File: tb/tb_gray_seq_checker.sv
// Bench for gray_seq_checker: directed scenarios then randomized upstream
// behaviour, every cycle compared against an arithmetic reference model.
module tb_gray_seq_checker;
  localparam int W   = 3;
  localparam int WW  = 8;
  localparam int MAXB = (1 << W) - 1;
  localparam int MAXW = (1 << WW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic [W-1:0]  gray = '0;
  logic          overflow = 1'b0;
  logic          clr_err = 1'b0;
  logic [W-1:0]  binary;
  logic          step, resync, error;
  logic [WW-1:0] wraps;

  int n_checks = 0;
  int n_err = 0;

  // reference model: mode 0 = waiting for first sample, 1 = tracking, 2 = faulted
  int m_mode, m_last, m_lovf, m_step, m_resync, m_wraps;

  int u, uo, r, v_r, c_r, o_lap;

  always #5 clk = ~clk;

  gray_seq_checker #(.WIDTH(W), .WRAP_W(WW)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .gray(gray), .overflow(overflow),
    .clr_err(clr_err), .binary(binary), .step(step), .resync(resync),
    .wraps(wraps), .error(error)
  );

  function automatic int g2b(input int g);
    int b = 0;
    for (int s = 0; s < W; s++) b = b ^ (g >> s);
    return b & MAXB;
  endfunction

  function automatic logic [W-1:0] b2g(input int b);
    int g;
    g = b ^ (b >> 1);
    return g[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_last = 0; m_lovf = 0; m_step = 0; m_resync = 0; m_wraps = 0;
  endtask

  task automatic model_edge(input int v, input int nb, input int o, input int c);
    m_step = 0;
    m_resync = 0;
    if (m_mode == 0) begin
      if (v != 0) begin m_last = nb; m_lovf = o; m_mode = 1; end
    end else if (m_mode == 1) begin
      if (v != 0) begin
        if (nb == m_last && o == m_lovf) begin
          m_step = 0;
        end else if (m_last != MAXB && nb == m_last + 1 && o == m_lovf) begin
          m_step = 1; m_last = nb;
        end else if (m_last == MAXB && nb == 0 && o == 1) begin
          m_step = 1; m_last = 0; m_lovf = 1;
          if (m_wraps < MAXW) m_wraps = m_wraps + 1;
        end else if (nb == 0 && o == 0 && (m_last != MAXB || m_lovf == 1)) begin
          m_resync = 1; m_last = 0; m_lovf = 0;
        end else begin
          m_mode = 2;
        end
      end
    end else begin
      if (c != 0) m_mode = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".binary"}, 32'(binary), 32'(m_last));
    chk({tag, ".step"},   32'(step),   32'(m_step));
    chk({tag, ".resync"}, 32'(resync), 32'(m_resync));
    chk({tag, ".wraps"},  32'(wraps),  32'(m_wraps));
    chk({tag, ".error"},  32'(error),  32'(m_mode == 2));
  endtask

  // drive one cycle of inputs, clock it, update the model, compare 1 time unit later
  task automatic cyc(input string tag, input int v, input int b, input int o, input int c);
    valid    = (v != 0);
    gray     = b2g(b);
    overflow = (o != 0);
    clr_err  = (c != 0);
    @(posedge clk);
    model_edge(v, g2b(int'(gray)), o, c);
    #1;
    check_all(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // 1: first lap from IDLE
    cyc("t1_first", 1, 0, 0, 0);
    chk("t1_first_nostep", 32'(step), 32'd0);
    for (int b = 1; b <= MAXB; b++) cyc("t1_lap", 1, b, 0, 0);
    chk("t1_bin7", 32'(binary), 32'd7);

    // 2: wrap with overflow rising, then a second lap
    cyc("t2_wrap", 1, 0, 1, 0);
    chk("t2_wraps1", 32'(wraps), 32'd1);
    chk("t2_wrapstep", 32'(step), 32'd1);
    for (int b = 1; b <= MAXB; b++) cyc("t2_lap", 1, b, 1, 0);
    cyc("t2_wrap2", 1, 0, 1, 0);
    chk("t2_wraps2", 32'(wraps), 32'd2);

    // 4: upstream reset from 5 with overflow set
    for (int b = 1; b <= 5; b++) cyc("t4_up", 1, b, 1, 0);
    cyc("t4_resync", 1, 0, 0, 0);
    chk("t4_resync_pulse", 32'(resync), 32'd1);
    chk("t4_resync_nostep", 32'(step), 32'd0);
    chk("t4_wraps_held", 32'(wraps), 32'd2);
    cyc("t4_after", 1, 0, 0, 0);
    chk("t4_resync_1cyc", 32'(resync), 32'd0);

    // 3: skip 2 -> 4 faults, samples ignored, clear wins over valid
    cyc("t3_up", 1, 1, 0, 0);
    cyc("t3_up", 1, 2, 0, 0);
    cyc("t3_skip", 1, 4, 0, 0);
    chk("t3_err", 32'(error), 32'd1);
    chk("t3_frozen", 32'(binary), 32'd2);
    cyc("t3_ign", 1, 5, 0, 0);
    cyc("t3_ign", 1, 0, 0, 0);
    cyc("t3_clr", 1, 3, 0, 1);
    chk("t3_cleared", 32'(error), 32'd0);
    chk("t3_dropped", 32'(binary), 32'd2);
    cyc("t3_idle_accept", 1, 3, 0, 0);
    chk("t3_accept_bin", 32'(binary), 32'd3);

    // 5: valid gaps, then overflow rising on 1 -> 2
    cyc("t5_resync", 1, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      cyc("t5_gap", 0, $urandom_range(0, MAXB), $urandom_range(0, 1), 0);
    cyc("t5_step", 1, 1, 0, 0);
    chk("t5_step_pulse", 32'(step), 32'd1);
    cyc("t5_ovf_rise", 1, 2, 1, 0);
    chk("t5_err", 32'(error), 32'd1);
    cyc("t5_clr", 0, 2, 1, 1);

    // 6: reach wraps=3 and a fault, then async reset between edges
    cyc("t6_first", 1, 0, 0, 0);
    for (int b = 1; b <= MAXB; b++) cyc("t6_lap", 1, b, 0, 0);
    cyc("t6_wrap", 1, 0, 1, 0);
    cyc("t6_step", 1, 1, 1, 0);
    cyc("t6_skip", 1, 3, 1, 0);
    chk("t6_err", 32'(error), 32'd1);
    chk("t6_wraps3", 32'(wraps), 32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_bin", 32'(binary), 32'd0);
    chk("t6_rst_err", 32'(error), 32'd0);
    chk("t6_rst_wraps", 32'(wraps), 32'd0);
    check_all("t6_rst");
    #3;
    rst_n = 1'b1;
    cyc("t6_post", 1, 6, 0, 0);
    chk("t6_post_bin", 32'(binary), 32'd6);
    chk("t6_post_nostep", 32'(step), 32'd0);

    // randomized upstream: mostly legal counting, with resets, glitches and clears
    u = 6; uo = 0;
    for (int k = 0; k < 1500; k++) begin
      r   = $urandom_range(0, 99);
      v_r = ($urandom_range(0, 3) != 0) ? 1 : 0;
      c_r = ($urandom_range(0, 7) == 0) ? 1 : 0;
      if (v_r != 0) begin
        if (r < 5) begin
          u = 0; uo = 0;
        end else if (r < 9) begin
          u = $urandom_range(0, MAXB); uo = $urandom_range(0, 1);
        end else if (r < 80) begin
          if (u == MAXB) begin u = 0; uo = 1; end
          else u = u + 1;
        end
      end
      cyc("rnd", v_r, u, uo, c_r);
    end

    // wrap counter saturation
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("sat_rst");
    rst_n = 1'b1;
    cyc("sat_first", 1, 0, 0, 0);
    o_lap = 0;
    for (int lap = 0; lap < MAXW + 5; lap++) begin
      for (int b = 1; b <= MAXB; b++) cyc("sat_lap", 1, b, o_lap, 0);
      o_lap = 1;
      cyc("sat_wrap", 1, 0, 1, 0);
    end
    chk("sat_wraps", 32'(wraps), 32'(MAXW));
    chk("sat_noerr", 32'(error), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
